emesh_ram_responder: RTL and testbench
======================================

EMESH_RAM_RESPONDER -- requirements
Module: emesh_ram_responder

Interface
REQ-001 Parameter PW, default 104, emesh packet width.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width and memory word width.
REQ-004 Parameter DEPTH, default 64, number of DW-bit memory words; power of two, at least 2.
REQ-005 axi_aclk  input  1  the only clock; all logic on its rising edge.
REQ-006 axi_aresetn  input  1  synchronous, active-low reset.
REQ-007 wr_access  input  1  write request valid.
REQ-008 wr_packet  input  PW  write request packet.
REQ-009 wr_wait  output  1  write request stall.
REQ-010 rd_access  input  1  read request valid.
REQ-011 rd_packet  input  PW  read request packet.
REQ-012 rd_wait  output  1  read request stall.
REQ-013 rr_access  output  1  read response valid.
REQ-014 rr_packet  output  PW  read response packet.
REQ-015 rr_wait  input  1  read response stall from the consumer.

Function
REQ-016 The packet layout SHALL be:
- [0] write
- [2:1] datamode (0 byte, 1 half, 2 word, 3 treated as word)
- [7:3] ctrlmode
- [39:8] dstaddr
- [71:40] data
- [103:72] srcaddr
REQ-017 The memory word index SHALL be dstaddr[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses alias modulo 4*DEPTH bytes.
REQ-018 The FSM SHALL have two states:
- INIT: clears one word per cycle using an index counter 0..DEPTH-1; moves to RUN on the cycle after the counter reaches DEPTH-1.
- RUN: the only other state; stays in RUN until reset.
REQ-019 wr_wait SHALL be 1 in INIT and 0 in RUN.
REQ-020 rd_wait SHALL equal (state==INIT) OR (rr_access AND rr_wait).
REQ-021 A write is accepted when wr_access=1 and wr_wait=0. The memory updates at that edge:
- byte mode: byte lane dstaddr[1:0] is taken from data[7:0].
- half mode: half lane dstaddr[1] is taken from data[15:0].
- word mode: the whole word is taken from data.
- All other lanes are unchanged.
REQ-022 A read is accepted when rd_access=1 and rd_wait=0. rr_access SHALL be 1 on the next cycle (latency 1).
REQ-023 The response SHALL be:
- write=1
- datamode and ctrlmode copied from the request
- dstaddr = request srcaddr
- srcaddr = 0
- data = the addressed lane right-justified and zero-extended (byte/half), or the full word.
REQ-024 Simultaneous write and read to the same word in one cycle SHALL return the pre-write contents (read-first).
REQ-025 While rr_access=1 and rr_wait=1, rr_access and rr_packet SHALL hold stable.
REQ-026 If rr_access=1, rr_wait=0 and no new read is accepted, rr_access SHALL fall next cycle.
REQ-027 Back-to-back reads with rr_wait=0 SHALL sustain one response per cycle.
REQ-028 The wr_packet write bit and the rd_packet write bit SHALL be ignored; the port on which the request arrives determines the operation.

Reset
REQ-029 While axi_aresetn=0 at a rising edge, the block SHALL set:
- state=INIT, counter=0
- rr_access=0, rr_packet=0
- wr_wait=1, rd_wait=1
REQ-030 Memory contents SHALL NOT be reset directly; after release, INIT zeroes all DEPTH words, so RUN begins exactly DEPTH cycles after release.
REQ-031 Reset asserted mid-operation SHALL discard any pending response, with no rr_access pulse after the reset edge, and SHALL restart INIT.
REQ-032 Requests presented during INIT SHALL NOT be accepted and SHALL have no effect.

Verification
REQ-033 Init: release reset, DEPTH=64 -> wr_wait=rd_wait=1 for 64 cycles, then 0; a read of every address returns data 0.
REQ-034 Word write/read:
- stimulus: write dstaddr 0x10 data 0xDEADBEEF, then read dstaddr 0x10, srcaddr 0x8000_0000.
- response: one cycle later rr_access=1, data 0xDEADBEEF, dstaddr 0x8000_0000, srcaddr 0, write=1.
REQ-035 Byte lanes:
- stimulus: write word 0 = 0x11223344, then byte write 0xAA at address 0x2, then byte read at 0x2 and word read at 0x0.
- response: byte read returns 0x000000AA; word read returns 0x11AA3344.
REQ-036 Backpressure:
- stimulus: hold rr_wait=1 after a read.
- response: rr_packet stable and rd_wait=1 while rr_wait=1.
- stimulus: drop rr_wait while a second read is pending.
- response: responses arrive in order, with no loss or duplication.
REQ-037 Collision and aliasing:
- stimulus: same-cycle write 0x5 and read at 0x20 over old value 0x7.
- response: returns 0x7; a later read returns 0x5.
- stimulus: write at 0x100 with DEPTH=64.
- response: read at 0x0 returns the same word.
REQ-038 Reset mid-stall: with rr_access=1 and rr_wait=1, assert axi_aresetn=0 for one cycle -> rr_access=0 next cycle and INIT restarts.

Source files
------------

// File: rtl/emesh_ram_responder.sv
// Emesh RAM responder: DEPTH x DW single-cycle memory, zeroed after reset, that answers
// write requests in place and turns read requests into emesh write-back responses.
module emesh_ram_responder #(
  parameter int unsigned PW    = 104,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic          axi_aclk,
  input  logic          axi_aresetn,
  input  logic          wr_access,
  input  logic [PW-1:0] wr_packet,
  output logic          wr_wait,
  input  logic          rd_access,
  input  logic [PW-1:0] rd_packet,
  output logic          rd_wait,
  output logic          rr_access,
  output logic [PW-1:0] rr_packet,
  input  logic          rr_wait
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned NumBytes = DW / 8;
  localparam int unsigned DstLo    = 8;
  localparam int unsigned DataLo   = 8 + AW;
  localparam int unsigned SrcLo    = 8 + AW + DW;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic            rr_access_q, rr_access_d;
  logic [PW-1:0]   rr_packet_q, rr_packet_d;

  logic [DW-1:0]   mem [DEPTH];

  logic            in_init;
  logic            wr_en, rd_en;
  logic [1:0]      wr_mode, rd_mode;
  logic [4:0]      rd_ctrl;
  logic [AW-1:0]   wr_addr, rd_addr, rd_src;
  logic [DW-1:0]   wr_data;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic [DW-1:0]   wr_word, rd_word, rd_data;

  // Packet field decode
  assign wr_mode = wr_packet[2:1];
  assign wr_addr = wr_packet[DstLo +: AW];
  assign wr_data = wr_packet[DataLo +: DW];
  assign wr_idx  = wr_addr[IdxW+1:2];

  assign rd_mode = rd_packet[2:1];
  assign rd_ctrl = rd_packet[7:3];
  assign rd_addr = rd_packet[DstLo +: AW];
  assign rd_src  = rd_packet[SrcLo +: AW];
  assign rd_idx  = rd_addr[IdxW+1:2];

  // Handshake
  assign in_init   = (state_q == StInit);
  assign wr_wait   = in_init;
  assign rd_wait   = in_init | (rr_access_q & rr_wait);
  assign wr_en     = wr_access & ~wr_wait;
  assign rd_en     = rd_access & ~rd_wait;
  assign rr_access = rr_access_q;
  assign rr_packet = rr_packet_q;

  // Merge write data into the current word, lane by lane
  always_comb begin
    wr_word = mem[wr_idx];
    for (int b = 0; b < NumBytes; b++) begin
      case (wr_mode)
        2'd0: if (wr_addr[1:0] == 2'(b)) wr_word[8*b +: 8] = wr_data[7:0];
        2'd1: if (wr_addr[1] == b[1]) wr_word[8*b +: 8] = wr_data[8*(b%2) +: 8];
        default: wr_word[8*b +: 8] = wr_data[8*b +: 8];
      endcase
    end
  end

  // Read lane select; the array read is combinational so a same-cycle write is not seen
  always_comb begin
    rd_word = mem[rd_idx];
    rd_data = '0;
    case (rd_mode)
      2'd0:    rd_data[7:0]  = rd_word[8*rd_addr[1:0] +: 8];
      2'd1:    rd_data[15:0] = rd_word[16*rd_addr[1] +: 16];
      default: rd_data       = rd_word;
    endcase
  end

  // Response register: load on accept, hold while stalled, drop once consumed
  always_comb begin
    rr_access_d = rr_access_q;
    rr_packet_d = rr_packet_q;
    if (rd_en) begin
      rr_access_d                  = 1'b1;
      rr_packet_d                  = '0;
      rr_packet_d[0]               = 1'b1;
      rr_packet_d[2:1]             = rd_mode;
      rr_packet_d[7:3]             = rd_ctrl;
      rr_packet_d[DstLo +: AW]     = rd_src;
      rr_packet_d[DataLo +: DW]    = rd_data;
    end else if (!rr_wait) begin
      rr_access_d = 1'b0;
    end
  end

  // Init sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IdxW'(DEPTH - 1)) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      rr_access_q <= 1'b0;
      rr_packet_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_access_q <= rr_access_d;
      rr_packet_q <= rr_packet_d;
    end
  end

  // Storage is never reset; INIT walks every word to zero instead
  always_ff @(posedge axi_aclk) begin
    if (axi_aresetn) begin
      if (in_init) begin
        mem[cnt_q] <= '0;
      end else if (wr_en) begin
        mem[wr_idx] <= wr_word;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wr_packet[0], wr_packet[7:3], wr_packet[PW-1:SrcLo],
                         wr_addr[AW-1:IdxW+2], rd_packet[0], rd_packet[DataLo +: DW],
                         rd_addr[AW-1:IdxW+2]};

endmodule

// File: tb/tb_emesh_ram_responder.sv
// Randomized and directed bench for emesh_ram_responder, checked every cycle against a
// word-array reference model plus literal expectations for the documented scenarios.
module tb_emesh_ram_responder;

  localparam int unsigned PW    = 104;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_access, rd_access, rr_wait;
  logic [PW-1:0] wr_packet, rd_packet;
  logic          wr_wait, rd_wait, rr_access;
  logic [PW-1:0] rr_packet;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  emesh_ram_responder #(
    .PW    (PW),
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rstn),
    .wr_access   (wr_access),
    .wr_packet   (wr_packet),
    .wr_wait     (wr_wait),
    .rd_access   (rd_access),
    .rd_packet   (rd_packet),
    .rd_wait     (rd_wait),
    .rr_access   (rr_access),
    .rr_packet   (rr_packet),
    .rr_wait     (rr_wait)
  );

  function automatic logic [103:0] mk(input logic w, input logic [1:0] mode,
                                      input logic [4:0] ctrl, input logic [31:0] dst,
                                      input logic [31:0] data, input logic [31:0] src);
    return {src, data, dst, ctrl, mode, w};
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'(a % (4 * DEPTH)) / 4;
  endfunction

  function automatic logic [31:0] lane_read(input logic [31:0] word, input logic [1:0] mode,
                                            input logic [31:0] addr);
    int sh;
    if (mode == 2'd0) begin
      sh = 8 * int'(addr[1:0]);
      return (word >> sh) & 32'hff;
    end else if (mode == 2'd1) begin
      sh = 16 * int'(addr[1]);
      return (word >> sh) & 32'hffff;
    end
    return word;
  endfunction

  function automatic logic [31:0] lane_write(input logic [31:0] old, input logic [1:0] mode,
                                             input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] mask, val;
    int sh;
    if (mode == 2'd0) begin
      sh   = 8 * int'(addr[1:0]);
      mask = 32'hff << sh;
      val  = (data & 32'hff) << sh;
    end else if (mode == 2'd1) begin
      sh   = 16 * int'(addr[1]);
      mask = 32'hffff << sh;
      val  = (data & 32'hffff) << sh;
    end else begin
      mask = 32'hffff_ffff;
      val  = data;
    end
    return (old & ~mask) | (val & mask);
  endfunction

  // Reference model: cycles-since-release decides INIT, a plain word array holds contents
  logic [31:0]  m_mem [DEPTH];
  int           m_init_cnt = 0;
  bit           m_init     = 1'b1;
  bit           m_acc      = 1'b0;
  logic [103:0] m_pkt      = '0;
  logic [31:0]  m_a, m_wa;

  always @(posedge clk) begin
    if (!rstn) begin
      m_init     = 1'b1;
      m_init_cnt = 0;
      m_acc      = 1'b0;
      m_pkt      = '0;
    end else if (m_init) begin
      m_init_cnt++;
      if (m_init_cnt == DEPTH) begin
        m_init = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      if (rd_access && !(m_acc && rr_wait)) begin
        m_a   = rd_packet[39:8];
        m_pkt = mk(1'b1, rd_packet[2:1], rd_packet[7:3], rd_packet[103:72],
                   lane_read(m_mem[m_idx(m_a)], rd_packet[2:1], m_a), 32'h0);
        m_acc = 1'b1;
      end else if (!rr_wait) begin
        m_acc = 1'b0;
      end
      if (wr_access) begin
        m_wa = wr_packet[39:8];
        m_mem[m_idx(m_wa)] = lane_write(m_mem[m_idx(m_wa)], wr_packet[2:1], m_wa,
                                        wr_packet[71:40]);
      end
    end
  end

  task automatic chk(input string name, input logic [103:0] got, input logic [103:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("wr_wait", wr_wait, m_init);
      chk("rd_wait", rd_wait, m_init | (m_acc & rr_wait));
      chk("rr_access", rr_access, m_acc);
      if (m_acc) chk("rr_packet", rr_packet, m_pkt);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input logic [1:0] mode, input logic [31:0] dst,
                            input logic [31:0] src);
    rd_access = 1'b1;
    rd_packet = mk(1'b0, mode, 5'h0, dst, 32'h0, src);
  endtask

  task automatic drive_write(input logic [1:0] mode, input logic [31:0] dst,
                             input logic [31:0] data);
    wr_access = 1'b1;
    wr_packet = mk(1'b0, mode, 5'h0, dst, data, 32'h0);
  endtask

  initial begin
    rstn      = 1'b0;
    wr_access = 1'b0;
    rd_access = 1'b0;
    rr_wait   = 1'b0;
    wr_packet = '0;
    rd_packet = '0;
    repeat (3) @(posedge clk);
    #1;
    fork
      compare_loop();
    join_none

    chk("reset_rr_access", rr_access, 1'b0);
    chk("reset_rr_packet", rr_packet, '0);
    chk("reset_wr_wait", wr_wait, 1'b1);
    chk("reset_rd_wait", rd_wait, 1'b1);

    // INIT window with requests that must be ignored
    rstn = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_access = 1'b1;
      wr_packet = mk(1'b1, 2'd2, 5'h0, $urandom, 32'hffff_ffff, $urandom);
      rd_access = 1'b1;
      rd_packet = mk(1'b0, 2'd2, 5'h0, $urandom, $urandom, $urandom);
      chk("init_wr_wait", wr_wait, 1'b1);
      cycle();
    end
    wr_access = 1'b0;
    rd_access = 1'b0;
    chk("run_wr_wait", wr_wait, 1'b0);
    chk("run_rd_wait", rd_wait, 1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      drive_read(2'd2, 32'(i * 4), 32'(i));
      cycle();
      chk("init_zero_acc", rr_access, 1'b1);
      chk("init_zero_data", rr_packet[71:40], 32'h0);
    end
    rd_access = 1'b0;
    cycle();

    // Word write then read
    drive_write(2'd2, 32'h10, 32'hDEAD_BEEF);
    cycle();
    wr_access = 1'b0;
    rd_access = 1'b1;
    rd_packet = mk(1'b0, 2'd2, 5'h3, 32'h10, 32'h0, 32'h8000_0000);
    cycle();
    rd_access = 1'b0;
    chk("word_acc", rr_access, 1'b1);
    chk("word_data", rr_packet[71:40], 32'hDEAD_BEEF);
    chk("word_dst", rr_packet[39:8], 32'h8000_0000);
    chk("word_src", rr_packet[103:72], 32'h0);
    chk("word_write", rr_packet[0], 1'b1);
    chk("word_ctrl", rr_packet[7:3], 5'h3);
    cycle();
    chk("word_drop", rr_access, 1'b0);

    // Byte lanes
    drive_write(2'd2, 32'h0, 32'h1122_3344);
    cycle();
    drive_write(2'd0, 32'h2, 32'h5555_55AA);
    cycle();
    wr_access = 1'b0;
    drive_read(2'd0, 32'h2, 32'h1);
    cycle();
    chk("byte_read", rr_packet[71:40], 32'h0000_00AA);
    drive_read(2'd2, 32'h0, 32'h2);
    cycle();
    chk("byte_word_read", rr_packet[71:40], 32'h11AA_3344);
    drive_read(2'd1, 32'h2, 32'h3);
    cycle();
    chk("half_read", rr_packet[71:40], 32'h0000_11AA);
    rd_access = 1'b0;
    cycle();

    // Same-cycle collision returns old contents
    drive_write(2'd2, 32'h20, 32'h7);
    cycle();
    drive_write(2'd2, 32'h20, 32'h5);
    drive_read(2'd2, 32'h20, 32'h4);
    cycle();
    wr_access = 1'b0;
    chk("collide_old", rr_packet[71:40], 32'h7);
    drive_read(2'd2, 32'h20, 32'h5);
    cycle();
    chk("collide_new", rr_packet[71:40], 32'h5);
    rd_access = 1'b0;

    // Aliasing modulo 4*DEPTH bytes
    drive_write(2'd2, 32'h100, 32'hCAFE_F00D);
    cycle();
    wr_access = 1'b0;
    drive_read(2'd2, 32'h0, 32'h6);
    cycle();
    chk("alias", rr_packet[71:40], 32'hCAFE_F00D);
    rd_access = 1'b0;
    cycle();

    // Backpressure with a second read pending
    rr_wait = 1'b1;
    drive_read(2'd2, 32'h10, 32'hA);
    cycle();
    drive_read(2'd2, 32'h0, 32'hB);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rd_wait", rd_wait, 1'b1);
      chk("bp_hold", rr_packet[71:40], 32'hDEAD_BEEF);
      cycle();
    end
    rr_wait = 1'b0;
    cycle();
    rd_access = 1'b0;
    chk("bp_second_data", rr_packet[71:40], 32'hCAFE_F00D);
    chk("bp_second_dst", rr_packet[39:8], 32'hB);
    cycle();
    chk("bp_drop", rr_access, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      wr_access = 1'($urandom);
      wr_packet = mk(1'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
      rd_access = ($urandom_range(0, 2) != 0);
      rd_packet = mk(1'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
      rr_wait   = ($urandom_range(0, 3) == 0);
      cycle();
    end
    wr_access = 1'b0;
    rd_access = 1'b0;
    rr_wait   = 1'b0;
    cycle();

    // Reset while a response is stalled
    rr_wait = 1'b1;
    drive_read(2'd2, 32'h10, 32'hC);
    cycle();
    rd_access = 1'b0;
    chk("rst_stall_acc", rr_access, 1'b1);
    rstn = 1'b0;
    cycle();
    chk("rst_drop_acc", rr_access, 1'b0);
    chk("rst_wr_wait", wr_wait, 1'b1);
    rstn    = 1'b1;
    rr_wait = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("reinit_rd_wait", rd_wait, 1'b1);
      chk("reinit_no_resp", rr_access, 1'b0);
      cycle();
    end
    chk("reinit_run", wr_wait, 1'b0);
    drive_read(2'd2, 32'h10, 32'hD);
    cycle();
    rd_access = 1'b0;
    chk("reinit_zero", rr_packet[71:40], 32'h0);
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
